// File: rtl/load_store_unit.sv
// Load/store unit: accepts byte/half/word loads and stores from the CPU and
// sequences them onto a single-ported, combinational-read data memory.
// Partial stores are done as read-modify-write (READ then WRITE); word stores
// go straight to WRITE; rejected requests respond immediately with resp_err.
module load_store_unit #(
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [31:0] WORD_LIMIT = 32'(MEM_WORDS);

   logic [1:0]  state;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        write_q;
   logic        uns_q;
   logic [15:0] wdata_q;
   logic        err_q;
   logic [31:0] rdata_q;
   logic [31:0] wword_q;

   logic        req_err;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_result;
   logic [31:0] merged_word;

   // Reject illegal sizes, misaligned accesses and addresses past the memory.
   always_comb begin
      req_err = 1'b0;
      case (req_size)
         SZ_BYTE: req_err = 1'b0;
         SZ_HALF: req_err = req_addr[0];
         SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
         default: req_err = 1'b1;
      endcase
      if ({2'b00, req_addr[31:2]} >= WORD_LIMIT) begin
         req_err = 1'b1;
      end
   end

   // Extract the addressed little-endian lane from the read word and extend it.
   always_comb begin
      byte_lane   = 8'h00;
      half_lane   = 16'h0000;
      load_result = '0;
      case (addr_q[1:0])
         2'd0:    byte_lane = mem_read_data[7:0];
         2'd1:    byte_lane = mem_read_data[15:8];
         2'd2:    byte_lane = mem_read_data[23:16];
         default: byte_lane = mem_read_data[31:24];
      endcase
      half_lane = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
      case (size_q)
         SZ_BYTE: load_result = {{24{~uns_q & byte_lane[7]}}, byte_lane};
         SZ_HALF: load_result = {{16{~uns_q & half_lane[15]}}, half_lane};
         default: load_result = mem_read_data;
      endcase
   end

   // Merge partial store data into the word read back during READ.
   always_comb begin
      merged_word = mem_read_data;
      if (size_q == SZ_HALF) begin
         if (addr_q[1]) begin
            merged_word[31:16] = wdata_q;
         end else begin
            merged_word[15:0] = wdata_q;
         end
      end else begin
         case (addr_q[1:0])
            2'd0:    merged_word[7:0]   = wdata_q[7:0];
            2'd1:    merged_word[15:8]  = wdata_q[7:0];
            2'd2:    merged_word[23:16] = wdata_q[7:0];
            default: merged_word[31:24] = wdata_q[7:0];
         endcase
      end
   end

   // Sequencer: capture the request in IDLE, then walk READ/WRITE/RESP.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         wword_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  size_q  <= req_size;
                  write_q <= req_write;
                  uns_q   <= req_unsigned;
                  wdata_q <= req_wdata[15:0];
                  err_q   <= req_err;
                  rdata_q <= '0;
                  // A word store needs no read-back, so its data is final now.
                  wword_q <= req_wdata;
                  if (req_err) begin
                     state <= RESP;
                  end else if (req_write && (req_size == SZ_WORD)) begin
                     state <= WRITE;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (write_q) begin
                  wword_q <= merged_word;
                  state   <= WRITE;
               end else begin
                  rdata_q <= load_result;
                  state   <= RESP;
               end
            end
            WRITE: begin
               state <= RESP;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Outputs decode from state and registers only; idle buses are held at 0.
   always_comb begin
      req_ready      = (state == IDLE);
      mem_read       = (state == READ);
      mem_write      = (state == WRITE);
      mem_address    = '0;
      mem_write_data = '0;
      resp_valid     = 1'b0;
      resp_rdata     = '0;
      resp_err       = 1'b0;
      if ((state == READ) || (state == WRITE)) begin
         mem_address = {2'b00, addr_q[31:2]};
      end
      if (state == WRITE) begin
         mem_write_data = wword_q;
      end
      if (state == RESP) begin
         resp_valid = 1'b1;
         resp_rdata = rdata_q;
         resp_err   = err_q;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, hand-written reset and
// back-to-back sequences, and random traffic checked against a byte-array model.
module tb_load_store_unit;

   localparam int MEM_WORDS = 64;
   localparam int AW = $clog2(MEM_WORDS);

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic [31:0] dev_mem [MEM_WORDS];
   logic        tb_we = 1'b0;
   logic [31:0] tb_wa = '0;
   logic [31:0] tb_wd = '0;

   logic [7:0]  ref_mem [MEM_WORDS*4];

   int tests = 0;
   int fails = 0;

   load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   // Attached data memory: combinational read, write on the rising edge.
   always_comb begin
      mem_read_data = (mem_address < 32'(MEM_WORDS)) ? dev_mem[mem_address[AW-1:0]] : 32'h0;
   end

   always @(posedge clk) begin
      if (tb_we) begin
         dev_mem[tb_wa[AW-1:0]] <= tb_wd;
      end else if (mem_write && (mem_address < 32'(MEM_WORDS))) begin
         dev_mem[mem_address[AW-1:0]] <= mem_write_data;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- reference model (byte-addressed memory) ----------------
   function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
      int unsigned nb;
      if (sz == 2'b11) return 1'b1;
      nb = 1 << sz;
      if ((a % nb) != 0) return 1'b1;
      if ((a / 4) >= MEM_WORDS) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
      longint v = 0;
      int nb = 1 << sz;
      for (int i = 0; i < nb; i++) v += longint'(ref_mem[a + i]) << (8 * i);
      if (!u && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
      return 32'(v);
   endfunction

   function automatic logic [31:0] model_word(input int idx);
      return {ref_mem[idx*4+3], ref_mem[idx*4+2], ref_mem[idx*4+1], ref_mem[idx*4]};
   endfunction

   task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int nb = 1 << sz;
      for (int i = 0; i < nb; i++) ref_mem[a + i] = 8'(wd >> (8 * i));
   endtask

   task automatic poke(input int idx, input logic [31:0] v);
      @(negedge clk);
      tb_we = 1'b1; tb_wa = 32'(idx); tb_wd = v;
      @(posedge clk);
      #1 tb_we = 1'b0;
      for (int i = 0; i < 4; i++) ref_mem[idx*4+i] = 8'(v >> (8 * i));
   endtask

   // One request: drive at a negedge, then observe each following cycle.
   task automatic access(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int nrd, output int nwr,
                         output logic [31:0] waddr, output logic [31:0] wword);
      @(negedge clk);
      chk("ready_idle", 32'(req_ready), 32'(1));
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      rdata = '0; err = 1'b0; lat = 0; nrd = 0; nwr = 0; waddr = '0; wword = '0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
            req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
         end
         chk("busy_not_ready", 32'(req_ready), 32'(0));
         if (mem_read && mem_write) chk("strobe_excl", 32'(1), 32'(0));
         if (!mem_read && !mem_write) begin
            chk("idle_addr_zero", mem_address, 32'(0));
            chk("idle_wdata_zero", mem_write_data, 32'(0));
         end
         if (mem_read) nrd++;
         if (mem_write) begin
            nwr++; waddr = mem_address; wword = mem_write_data;
         end
         if (resp_valid) begin
            lat = cyc; rdata = resp_rdata; err = resp_err;
            break;
         end
      end
   endtask

   // Run one request and compare everything against the model.
   task automatic run_check(input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] o_rd, output logic o_err, output int o_lat);
      logic        e_err;
      logic [31:0] e_rd;
      int          e_lat, e_nrd, e_nwr, nrd, nwr;
      logic [31:0] waddr, wword;
      e_err = model_err(sz, a);
      e_rd  = (!e_err && !w) ? model_load(sz, u, a) : 32'h0;
      e_lat = e_err ? 1 : ((w && sz != 2'b10) ? 3 : 2);
      e_nrd = (e_err || (w && sz == 2'b10)) ? 0 : 1;
      e_nwr = (!e_err && w) ? 1 : 0;
      if (!e_err && w) model_store(sz, a, wd);
      access(w, sz, u, a, wd, o_rd, o_err, o_lat, nrd, nwr, waddr, wword);
      chk("rdata", o_rd, e_rd);
      chk("err", 32'(o_err), 32'(e_err));
      chk("latency", 32'(o_lat), 32'(e_lat));
      chk("mem_read_cycles", 32'(nrd), 32'(e_nrd));
      chk("mem_write_cycles", 32'(nwr), 32'(e_nwr));
      if (e_nwr == 1) begin
         chk("write_address", waddr, a >> 2);
         chk("write_data", wword, model_word(int'(a >> 2)));
         chk("mem_contents", dev_mem[a[AW+1:2]], model_word(int'(a >> 2)));
      end
   endtask

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        err;
      int          lat;
      int          wi;
      logic [31:0] wv;
   } vec_t;

   vec_t tbl [15];

   initial begin
      logic [31:0] rd, waddr, wword;
      logic        er;
      int          lt, nrd, nwr, seen_w, seen_r;
      logic [31:0] old5;

      tbl[0]  = '{w:1'b0, sz:2'b00, u:1'b0, a:32'h0E,  wd:32'h0,        rd:32'hFFFFFFFF, err:1'b0, lat:2, wi:-1, wv:32'h0};
      tbl[1]  = '{w:1'b0, sz:2'b00, u:1'b1, a:32'h0E,  wd:32'h0,        rd:32'h000000FF, err:1'b0, lat:2, wi:-1, wv:32'h0};
      tbl[2]  = '{w:1'b0, sz:2'b01, u:1'b0, a:32'h0E,  wd:32'h0,        rd:32'hFFFF80FF, err:1'b0, lat:2, wi:-1, wv:32'h0};
      tbl[3]  = '{w:1'b0, sz:2'b01, u:1'b1, a:32'h0E,  wd:32'h0,        rd:32'h000080FF, err:1'b0, lat:2, wi:-1, wv:32'h0};
      tbl[4]  = '{w:1'b0, sz:2'b10, u:1'b0, a:32'h0C,  wd:32'h0,        rd:32'h80FF1234, err:1'b0, lat:2, wi:-1, wv:32'h0};
      tbl[5]  = '{w:1'b0, sz:2'b00, u:1'b0, a:32'h0F,  wd:32'h0,        rd:32'hFFFFFF80, err:1'b0, lat:2, wi:-1, wv:32'h0};
      tbl[6]  = '{w:1'b1, sz:2'b00, u:1'b0, a:32'h0D,  wd:32'h777777AB, rd:32'h0,        err:1'b0, lat:3, wi:3,  wv:32'h80FFAB34};
      tbl[7]  = '{w:1'b1, sz:2'b10, u:1'b0, a:32'h10,  wd:32'hDEADBEEF, rd:32'h0,        err:1'b0, lat:2, wi:4,  wv:32'hDEADBEEF};
      tbl[8]  = '{w:1'b0, sz:2'b01, u:1'b0, a:32'h0F,  wd:32'h0,        rd:32'h0,        err:1'b1, lat:1, wi:-1, wv:32'h0};
      tbl[9]  = '{w:1'b0, sz:2'b10, u:1'b0, a:32'h100, wd:32'h0,        rd:32'h0,        err:1'b1, lat:1, wi:-1, wv:32'h0};
      tbl[10] = '{w:1'b0, sz:2'b11, u:1'b0, a:32'h0C,  wd:32'h0,        rd:32'h0,        err:1'b1, lat:1, wi:-1, wv:32'h0};
      tbl[11] = '{w:1'b0, sz:2'b10, u:1'b0, a:32'h10,  wd:32'h0,        rd:32'hDEADBEEF, err:1'b0, lat:2, wi:-1, wv:32'h0};
      tbl[12] = '{w:1'b1, sz:2'b01, u:1'b0, a:32'h12,  wd:32'hCCCC5678, rd:32'h0,        err:1'b0, lat:3, wi:4,  wv:32'h5678BEEF};
      tbl[13] = '{w:1'b0, sz:2'b10, u:1'b0, a:32'h10,  wd:32'h0,        rd:32'h5678BEEF, err:1'b0, lat:2, wi:-1, wv:32'h0};
      tbl[14] = '{w:1'b0, sz:2'b00, u:1'b1, a:32'h0D,  wd:32'h0,        rd:32'h000000AB, err:1'b0, lat:2, wi:-1, wv:32'h0};

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

      // Preload memory (under reset), then fix words 3 and 4.
      for (int i = 0; i < MEM_WORDS; i++) poke(i, $urandom);
      poke(3, 32'h80FF1234);
      poke(4, 32'h00000000);

      @(negedge clk);
      chk("reset_ready", 32'(req_ready), 32'(1));
      chk("reset_resp_valid", 32'(resp_valid), 32'(0));
      chk("reset_rdata", resp_rdata, 32'(0));
      chk("reset_err", 32'(resp_err), 32'(0));
      chk("reset_strobes", {30'b0, mem_read, mem_write}, 32'(0));
      chk("reset_addr", mem_address, 32'(0));
      chk("reset_wdata", mem_write_data, 32'(0));
      reset = 1'b0;

      // Directed vectors.
      for (int i = 0; i < 15; i++) begin
         run_check(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, rd, er, lt);
         chk("tbl_rdata", rd, tbl[i].rd);
         chk("tbl_err", 32'(er), 32'(tbl[i].err));
         chk("tbl_latency", 32'(lt), 32'(tbl[i].lat));
         if (tbl[i].wi >= 0) chk("tbl_mem_word", dev_mem[tbl[i].wi], tbl[i].wv);
      end

      // Reset during the READ cycle of a byte store abandons it.
      poke(3, 32'h80FF1234);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0D; req_wdata = 32'h000000AB;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_read_strobe", 32'(mem_read), 32'(1));
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_read_idle", 32'(req_ready), 32'(1));
      seen_w = 0; seen_r = 0;
      for (int c = 0; c < 4; c++) begin
         if (mem_write) seen_w++;
         if (resp_valid) seen_r++;
         @(negedge clk);
      end
      chk("rst_read_no_write", 32'(seen_w), 32'(0));
      chk("rst_read_no_resp", 32'(seen_r), 32'(0));
      chk("rst_read_word3", dev_mem[3], 32'h80FF1234);

      // Reset during WRITE drops the strobe; store the current value so the
      // memory contents are the same whether or not that edge wrote.
      old5 = model_word(5);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h14; req_wdata = old5;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_write_strobe", 32'(mem_write), 32'(1));
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_write_dropped", 32'(mem_write), 32'(0));
      seen_r = 0;
      for (int c = 0; c < 4; c++) begin
         if (resp_valid) seen_r++;
         @(negedge clk);
      end
      chk("rst_write_no_resp", 32'(seen_r), 32'(0));
      chk("rst_write_word5", dev_mem[5], old5);

      // Back-to-back loads with req_valid held high.
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h0C;
      @(posedge clk);
      @(negedge clk);
      chk("b2b_busy1", 32'(req_ready), 32'(0));
      chk("b2b_read1", 32'(mem_read), 32'(1));
      req_addr = 32'h10;
      @(negedge clk);
      chk("b2b_resp1", 32'(resp_valid), 32'(1));
      chk("b2b_rdata1", resp_rdata, model_load(2'b10, 1'b0, 32'h0C));
      chk("b2b_busy_resp", 32'(req_ready), 32'(0));
      @(negedge clk);
      chk("b2b_idle", 32'(req_ready), 32'(1));
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b_accept2", 32'(mem_read), 32'(1));
      chk("b2b_addr2", mem_address, 32'(4));
      @(negedge clk);
      chk("b2b_resp2", 32'(resp_valid), 32'(1));
      chk("b2b_rdata2", resp_rdata, model_load(2'b10, 1'b0, 32'h10));

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         int unsigned r;
         logic [1:0]  sz;
         logic [31:0] a;
         r = $urandom_range(0, 9);
         sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 300));
         if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
         run_check(1'($urandom), sz, 1'($urandom), a, $urandom, rd, er, lt);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
